avmm_pio_v2: RTL and testbench
==============================

# avmm_pio_v2

Parametrised Avalon-MM slave parallel I/O block, successor to the fixed 16-bit output-only PIO used for the hex-digit display. Provides an output register of configurable width with atomic bit set/clear, a synchronised input port with per-bit edge capture, an interrupt mask and a level interrupt. Sits on the system interconnect alongside the existing PIOs; one instance per peripheral group (hex digits, LEDs, keys, switches).

## Interface
- OUT_W, 16, output port width, 1..32
- IN_W, 8, input port width, 1..32
- SYNC_STAGES, 2, input synchroniser depth, 2..4
- RESET_VAL, 0, out_port value after reset (OUT_W bits)
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low; clock clk
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  write strobe, active-low
- read_n  in  1  read strobe, active-low
- writedata  in  32  write data; bits above the register width are ignored
- readdata  out  32  read data, zero-extended
- in_port  in  IN_W  asynchronous external inputs
- out_port  out  OUT_W  registered outputs
- irq  out  1  level interrupt, active-high

## Operation
- Register map, word addresses:
  - 0 DATA (RW): read and write out register.
  - 1 IN (RO): synchronised in_port.
  - 2 IRQ_MASK (RW): IN_W bits.
  - 3 EDGE_CAP (R, W1C): captured edges.
  - 4 OUTSET (WO): 1-bits set out register bits.
  - 5 OUTCLR (WO): 1-bits clear out register bits.
  - 6–7: reserved; read 0, writes ignored. Write-only registers read 0.
- Write is accepted when chipselect && !write_n. Read is accepted when chipselect && !read_n. Simultaneous read and write are both performed; read returns the pre-write value.
- Edge detection compares the last synchroniser stage with a one-cycle-delayed copy. A rising edge sets the EDGE_CAP bit.
- Arming: a counter holds edge detection disabled for SYNC_STAGES+1 cycles after reset release, so inputs static through reset produce no capture.
- Same cycle edge detect and W1C of the same bit: the set wins and the bit stays 1.
- irq = |(EDGE_CAP & IRQ_MASK), driven from registers, with no extra latency.
- Reset values:
  - out_port = RESET_VAL.
  - readdata = 0.
  - IRQ_MASK = 0, EDGE_CAP = 0, irq = 0.
  - Synchroniser and delay registers = 0.
  - Arm counter = 0 (disarmed).
- Asserting reset mid-transaction aborts it; no partial state survives.

## Timing
- Read latency 1: readdata is registered on the clk edge that accepts the read and is valid the following cycle. readdata holds its value between reads.
- DATA, OUTSET and OUTCLR writes update out_port on the accepting edge. The new value is visible the next cycle. No wait states.
- in_port change appears in IN after SYNC_STAGES edges. The EDGE_CAP bit and irq assert after SYNC_STAGES+1 edges.
- W1C takes effect on the accepting edge; irq deasserts in the same cycle EDGE_CAP clears.

## Configuration
- PIO_BOTH_EDGE_EN defined: EDGE_CAP captures both rising and falling edges.
- PIO_BOTH_EDGE_EN undefined: EDGE_CAP captures rising edges only; falling-edge logic is not built.

## Structure
- Shared package pio_pkg holds:
  - Register address localparams: ADDR_DATA, ADDR_IN, ADDR_IRQ_MASK, ADDR_EDGE_CAP, ADDR_OUTSET, ADDR_OUTCLR.
  - Maximum width constant PIO_MAX_W = 32.
- Sub-module pio_sync_edge (parameters W, SYNC_STAGES) contains the synchroniser chain, delay register, arm counter and per-bit edge pulse. Top level holds the register file, read mux and irq.

## Test plan
All scenarios use OUT_W=16, IN_W=8, SYNC_STAGES=2, RESET_VAL=0x00A5.
- Reset:
  - Assert reset_n low mid-run → out_port=0x00A5, readdata=0, irq=0 immediately.
  - Read addr 2 and 3 after release → 0 and 0.
- DATA path:
  - Write 0x1234ABCD to addr 0 → out_port=0xABCD on the next cycle.
  - Read addr 0 → readdata=0x0000ABCD one cycle after the read.
- Set/clear:
  - From 0xABCD, write 0x00F0 to OUTSET → 0xABFD.
  - Then write 0x000D to OUTCLR → 0xABF0.
  - Read addr 4 → 0.
- Capture/irq:
  - IRQ_MASK=0x04, in_port 0x00→0x05 → after 3 edges EDGE_CAP=0x05, irq=1.
  - Write 0x04 to addr 3 → EDGE_CAP=0x01, irq=0.
- Collision: a bit-0 rising edge detected in the same cycle as a W1C of 0x01 → EDGE_CAP bit 0 stays 1.
- Reset-held input and falling edge:
  - in_port=0xFF held through reset release → EDGE_CAP stays 0.
  - Then in_port 0xFF→0x00 → EDGE_CAP=0xFF with PIO_BOTH_EDGE_EN defined, 0x00 without.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared definitions for the Avalon-MM PIO block.
// Holds the register word addresses and the bus width limit.
package pio_pkg;

    localparam int PIO_MAX_W = 32;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_IN       = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser, delay register, arm counter and per-bit edge pulse.
// Ports: clk, reset_n (async, active-low), din (async inputs),
//   sync_out (last synchroniser stage), edge_pulse (one-cycle edge flags).
// Build option: PIO_BOTH_EDGE_EN also flags falling edges.
module pio_sync_edge #(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] sync_out,
    output logic [W-1:0] edge_pulse
);

    localparam logic [2:0] ARM_N = 3'(SYNC_STAGES + 1);

    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] dly_q;
    logic [2:0]   arm_cnt;
    logic         armed;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            dly_q   <= '0;
            arm_cnt <= '0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            dly_q <= sync_q[SYNC_STAGES-1];
            if (arm_cnt != ARM_N) arm_cnt <= arm_cnt + 3'd1;
        end
    end

    // The chain and delay register leave reset at 0, so an input held
    // high through reset looks like a rising edge until the chain fills.
    // Detection stays off until that transient has passed.
    assign armed    = (arm_cnt == ARM_N);
    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PIO_BOTH_EDGE_EN
    assign edge_pulse = armed ? (sync_out ^ dly_q) : '0;
`else
    assign edge_pulse = armed ? (sync_out & ~dly_q) : '0;
`endif

endmodule

// File: rtl/avmm_pio_v2.sv
// Avalon-MM parallel I/O slave: output register with set/clear, synchronised
// input with edge capture, interrupt mask and level irq.
// Ports: clk, reset_n (async, active-low), address/chipselect/write_n/read_n/
//   writedata/readdata (Avalon-MM, read latency 1), in_port, out_port, irq.
// Build option: PIO_BOTH_EDGE_EN captures falling as well as rising edges.
module avmm_pio_v2
    import pio_pkg::*;
#(
    parameter int               OUT_W       = 16,
    parameter int               IN_W        = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [OUT_W-1:0] RESET_VAL   = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic                 read_n,
    input  logic [PIO_MAX_W-1:0] writedata,
    output logic [PIO_MAX_W-1:0] readdata,
    input  logic [IN_W-1:0]      in_port,
    output logic [OUT_W-1:0]     out_port,
    output logic                 irq
);

    logic            wr_en;
    logic            rd_en;
    logic [OUT_W-1:0] out_q;
    logic [IN_W-1:0] mask_q;
    logic [IN_W-1:0] cap_q;
    logic [IN_W-1:0] in_sync;
    logic [IN_W-1:0] edge_pulse;
    logic [IN_W-1:0] w1c;
    logic [OUT_W-1:0] wd_out;
    logic [IN_W-1:0] wd_in;
    logic [PIO_MAX_W-1:0] rd_mux;
    logic            unused_ok;

    pio_sync_edge #(
        .W           (IN_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .din        (in_port),
        .sync_out   (in_sync),
        .edge_pulse (edge_pulse)
    );

    assign wr_en  = chipselect && !write_n;
    assign rd_en  = chipselect && !read_n;
    assign wd_out = writedata[OUT_W-1:0];
    assign wd_in  = writedata[IN_W-1:0];
    assign w1c    = (wr_en && address == ADDR_EDGE_CAP) ? wd_in : '0;

    // Upper write-data bits are intentionally ignored.
    assign unused_ok = &{1'b0, writedata};

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:     rd_mux[OUT_W-1:0] = out_q;
            ADDR_IN:       rd_mux[IN_W-1:0]  = in_sync;
            ADDR_IRQ_MASK: rd_mux[IN_W-1:0]  = mask_q;
            ADDR_EDGE_CAP: rd_mux[IN_W-1:0]  = cap_q;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q    <= RESET_VAL;
            mask_q   <= '0;
            cap_q    <= '0;
            readdata <= '0;
        end else begin
            if (rd_en) readdata <= rd_mux;
            if (wr_en) begin
                case (address)
                    ADDR_DATA:     out_q  <= wd_out;
                    ADDR_OUTSET:   out_q  <= out_q | wd_out;
                    ADDR_OUTCLR:   out_q  <= out_q & ~wd_out;
                    ADDR_IRQ_MASK: mask_q <= wd_in;
                    default:       ;
                endcase
            end
            // A fresh edge overrides a same-cycle clear of that bit.
            cap_q <= (cap_q & ~w1c) | edge_pulse;
        end
    end

    assign out_port = out_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_avmm_pio_v2.sv
// Directed self-checking bench for avmm_pio_v2.
// Scenario tasks run in sequence; each compares DUT outputs against constants.
module tb_avmm_pio_v2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic        read_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  in_port = '0;
    logic [15:0] out_port;
    logic        irq;

    int errors = 0;
    int checks = 0;

    avmm_pio_v2 #(
        .OUT_W       (16),
        .IN_W        (8),
        .SYNC_STAGES (2),
        .RESET_VAL   (16'h00A5)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .read_n     (read_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1;
        d = readdata;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(2);
        bus_write(3'd0, 32'h0000_1111);
        bus_read(3'd0, rd);
        checks++;
        if (rd !== 32'h0000_1111) begin
            errors++; $display("FAIL pre_reset_read got=%h exp=%h", rd, 32'h1111);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (out_port !== 16'h00A5) begin
            errors++; $display("FAIL reset_out got=%h exp=00a5", out_port);
        end
        checks++;
        if (readdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got=%h exp=0", readdata);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL reset_irq got=%b exp=0", irq);
        end
        idle(2);
        reset_n = 1'b1;
        bus_read(3'd2, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL reset_mask got=%h exp=0", rd);
        end
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL reset_cap got=%h exp=0", rd);
        end
    endtask

    task automatic test_data;
        logic [31:0] rd;
        bus_write(3'd0, 32'h1234_ABCD);
        checks++;
        if (out_port !== 16'hABCD) begin
            errors++; $display("FAIL data_out got=%h exp=abcd", out_port);
        end
        bus_read(3'd0, rd);
        checks++;
        if (rd !== 32'h0000_ABCD) begin
            errors++; $display("FAIL data_read got=%h exp=0000abcd", rd);
        end
    endtask

    task automatic test_set_clear;
        logic [31:0] rd;
        bus_write(3'd4, 32'h0000_00F0);
        checks++;
        if (out_port !== 16'hABFD) begin
            errors++; $display("FAIL outset got=%h exp=abfd", out_port);
        end
        bus_write(3'd5, 32'h0000_000D);
        checks++;
        if (out_port !== 16'hABF0) begin
            errors++; $display("FAIL outclr got=%h exp=abf0", out_port);
        end
        bus_read(3'd4, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL read_outset got=%h exp=0", rd);
        end
        bus_read(3'd6, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL read_rsvd got=%h exp=0", rd);
        end
    endtask

    task automatic test_rw_same;
        @(negedge clk);
        address = 3'd0; writedata = 32'h0000_5A5A;
        chipselect = 1'b1; write_n = 1'b0; read_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
        checks++;
        if (readdata !== 32'h0000_ABF0) begin
            errors++; $display("FAIL rw_read got=%h exp=0000abf0", readdata);
        end
        checks++;
        if (out_port !== 16'h5A5A) begin
            errors++; $display("FAIL rw_write got=%h exp=5a5a", out_port);
        end
    endtask

    task automatic test_capture;
        logic [31:0] rd;
        bus_write(3'd2, 32'h04);
        in_port = 8'h05;
        idle(2);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_early got=%b exp=0", irq);
        end
        idle(1);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_set got=%b exp=1", irq);
        end
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h05) begin
            errors++; $display("FAIL cap_val got=%h exp=05", rd);
        end
        bus_read(3'd1, rd);
        checks++;
        if (rd !== 32'h05) begin
            errors++; $display("FAIL in_val got=%h exp=05", rd);
        end
        bus_write(3'd3, 32'h04);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_clr got=%b exp=0", irq);
        end
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h01) begin
            errors++; $display("FAIL cap_w1c got=%h exp=01", rd);
        end
    endtask

    task automatic test_collision;
        logic [31:0] rd;
        in_port = 8'h04;
        idle(5);
        bus_write(3'd3, 32'hFF);
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h00) begin
            errors++; $display("FAIL coll_pre got=%h exp=00", rd);
        end
        @(negedge clk);
        in_port = 8'h05;
        @(negedge clk);
        bus_write(3'd3, 32'h01);
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h01) begin
            errors++; $display("FAIL coll_set_wins got=%h exp=01", rd);
        end
        bus_write(3'd3, 32'hFF);
    endtask

    task automatic test_reset_held;
        logic [31:0] rd;
        logic [31:0] exp_fall;
`ifdef PIO_BOTH_EDGE_EN
        exp_fall = 32'hFF;
`else
        exp_fall = 32'h00;
`endif
        in_port = 8'hFF;
        @(negedge clk);
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(6);
        bus_read(3'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL held_cap got=%h exp=0", rd);
        end
        in_port = 8'h00;
        idle(5);
        bus_read(3'd3, rd);
        checks++;
        if (rd !== exp_fall) begin
            errors++; $display("FAIL fall_cap got=%h exp=%h", rd, exp_fall);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL fall_irq got=%b exp=0", irq);
        end
    endtask

    initial begin
        test_reset();
        test_data();
        test_set_clear();
        test_rw_same();
        test_capture();
        test_collision();
        test_reset_held();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
